// File: rtl/stage_led_driver.sv
// Stage-coloured RGB LED driver with a PWM fade-in and a change-strobed data snapshot.
// Optional macro STAGE_LED_FADE_EN enables the gradual duty ramp; otherwise FADE jumps to BRIGHT.
module stage_led_driver #(
    parameter int PWM_BITS = 8,
    parameter int BRIGHT   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stage_in,
    input  logic [15:0] data_in,
    output logic [2:0]  led_rgb,
    output logic [15:0] data_out,
    output logic        change_pulse
);

    localparam logic [PWM_BITS-1:0] W_BRIGHT = PWM_BITS'(BRIGHT);
    localparam logic [PWM_BITS-1:0] W_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_OFF,
        S_FADE,
        S_STEADY
    } state_t;

    logic [2:0]          r_stage_s1;
    logic [2:0]          r_stage_s2;
    logic [15:0]         r_data_s1;
    logic [15:0]         r_data_s2;
    logic [15:0]         r_data_out;
    logic                r_pulse;
    logic [2:0]          r_stage;
    logic [2:0]          r_colour;
    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic [1:0]          r_vld;
    state_t              r_state;

    logic                w_stage_chg;
    logic                w_data_chg;
    logic                w_wrap;
    logic [2:0]          w_colour;

    assign w_stage_chg = (r_stage_s2 != r_stage);
    assign w_data_chg  = (r_data_s2 != r_data_out);
    assign w_wrap      = (r_cnt == W_CNT_MAX);

    always_comb begin
        w_colour = 3'b000;
        unique case (r_stage_s2)
            3'd0:    w_colour = 3'b001;
            3'd1:    w_colour = 3'b010;
            3'd2:    w_colour = 3'b011;
            3'd3:    w_colour = 3'b100;
            3'd4:    w_colour = 3'b101;
            3'd5:    w_colour = 3'b110;
            3'd6:    w_colour = 3'b111;
            default: w_colour = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_s1 <= '0;
            r_stage_s2 <= '0;
            r_data_s1  <= '0;
            r_data_s2  <= '0;
            r_data_out <= '0;
            r_pulse    <= 1'b0;
            r_cnt      <= '0;
            r_vld      <= '0;
        end else begin
            r_stage_s1 <= stage_in;
            r_stage_s2 <= r_stage_s1;
            r_data_s1  <= data_in;
            r_data_s2  <= r_data_s1;
            r_pulse    <= w_data_chg;
            if (w_data_chg) begin
                r_data_out <= r_data_s2;
            end
            r_cnt <= r_cnt + 1'b1;
            r_vld <= {r_vld[0], 1'b1};
        end
    end

    // OFF keeps tracking the stage so stage 0 still gets its colour on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage  <= '0;
            r_colour <= 3'b000;
            r_duty   <= '0;
            r_state  <= S_OFF;
        end else begin
            unique case (r_state)
                S_OFF: begin
                    r_duty   <= '0;
                    r_stage  <= r_stage_s2;
                    r_colour <= w_colour;
                    if (r_vld[1]) begin
                        r_state <= S_FADE;
                    end
                end
                S_FADE: begin
                    if (w_stage_chg) begin
                        r_stage  <= r_stage_s2;
                        r_colour <= w_colour;
                        r_duty   <= '0;
                    end else begin
`ifdef STAGE_LED_FADE_EN
                        if (r_duty == W_BRIGHT) begin
                            r_state <= S_STEADY;
                        end else if (w_wrap) begin
                            r_duty <= r_duty + 1'b1;
                        end
`else
                        r_duty  <= W_BRIGHT;
                        r_state <= S_STEADY;
`endif
                    end
                end
                S_STEADY: begin
                    if (w_stage_chg) begin
                        r_stage  <= r_stage_s2;
                        r_colour <= w_colour;
                        r_duty   <= '0;
                        r_state  <= S_FADE;
                    end else begin
                        r_duty <= W_BRIGHT;
                    end
                end
                default: begin
                    r_duty  <= '0;
                    r_state <= S_OFF;
                end
            endcase
        end
    end

    always_comb begin
        led_rgb = 3'b000;
        if (r_state != S_OFF && r_cnt < r_duty) begin
            led_rgb = r_colour;
        end
    end

    assign data_out     = r_data_out;
    assign change_pulse = r_pulse;

endmodule
